// File: rtl/e_term_loopback_cfg.sv
// East-edge termination switch matrix: loops END wires back onto BEG wires in bit-reversed order,
// with per-group bypass / pipelined / tie-low / PRBS modes loaded through a serial config chain.
module e_term_loopback_cfg #(
  parameter int unsigned WIDTH      = 48,
  parameter int unsigned GROUP_W    = 4,
  parameter int unsigned NUM_GROUPS = 12,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             UserCLK,
  input  logic             rst,
  input  logic [WIDTH-1:0] end_in,
  output logic [WIDTH-1:0] beg_out,
  input  logic             cfg_shift_en,
  input  logic             cfg_data_in,
  input  logic             cfg_load,
  output logic             cfg_data_out
);

  localparam int unsigned CFG_W = 2 * NUM_GROUPS;

  localparam logic [1:0] ModeBypass = 2'b00;
  localparam logic [1:0] ModePipe   = 2'b01;
  localparam logic [1:0] ModeTie0   = 2'b10;
  localparam logic [1:0] ModePrbs   = 2'b11;

  logic [CFG_W-1:0] r_shadow;
  logic [CFG_W-1:0] r_active;
  logic [WIDTH-1:0] r_pipe [PIPE_DEPTH];
  logic [15:0]      r_lfsr;

  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_prbs;
  logic             w_any_prbs;
  logic             w_lfsr_fb;

  for (genvar i = 0; i < WIDTH; i++) begin : g_map
    assign w_rev[i]  = end_in[WIDTH-1-i];
    assign w_prbs[i] = r_lfsr[i % 16];
  end

  // Load samples the pre-shift shadow, so a same-cycle shift only affects the next commit.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (cfg_load) begin
        r_active <= r_shadow;
      end
      if (cfg_shift_en) begin
        r_shadow <= {r_shadow[CFG_W-2:0], cfg_data_in};
      end
    end
  end

  assign cfg_data_out = r_shadow[CFG_W-1];

  // Delay line runs on every wire regardless of mode so PIPE groups never see a refill bubble.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0] <= w_rev;
      for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  always_comb begin
    w_any_prbs = 1'b0;
    for (int g = 0; g < int'(NUM_GROUPS); g++) begin
      if (r_active[2*g +: 2] == ModePrbs) begin
        w_any_prbs = 1'b1;
      end
    end
  end

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_any_prbs) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  always_comb begin
    beg_out = '0;
    for (int g = 0; g < int'(NUM_GROUPS); g++) begin
      unique case (r_active[2*g +: 2])
        ModeBypass: beg_out[g*GROUP_W +: GROUP_W] = w_rev[g*GROUP_W +: GROUP_W];
        ModePipe:   beg_out[g*GROUP_W +: GROUP_W] = r_pipe[PIPE_DEPTH-1][g*GROUP_W +: GROUP_W];
        ModeTie0:   beg_out[g*GROUP_W +: GROUP_W] = '0;
        ModePrbs:   beg_out[g*GROUP_W +: GROUP_W] = w_prbs[g*GROUP_W +: GROUP_W];
      endcase
    end
  end

endmodule

// File: tb/tb_e_term_loopback_cfg.sv
// Randomized and directed bench for e_term_loopback_cfg against a cycle-indexed behavioural model.
module tb_e_term_loopback_cfg;

  localparam int W     = 48;
  localparam int GW    = 4;
  localparam int NG    = 12;
  localparam int DEPTH = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  end_in;
  logic [W-1:0]  beg_out;
  logic          cfg_shift_en;
  logic          cfg_data_in;
  logic          cfg_load;
  logic          cfg_data_out;

  logic [W-1:0]  ch_end_in;
  logic [W-1:0]  a_beg;
  logic [W-1:0]  b_beg;
  logic          a_dout;
  logic          b_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  e_term_loopback_cfg dut (
    .UserCLK(clk), .rst(rst), .end_in(end_in), .beg_out(beg_out),
    .cfg_shift_en(cfg_shift_en), .cfg_data_in(cfg_data_in), .cfg_load(cfg_load),
    .cfg_data_out(cfg_data_out)
  );

  e_term_loopback_cfg u_a (
    .UserCLK(clk), .rst(rst), .end_in(ch_end_in), .beg_out(a_beg),
    .cfg_shift_en(cfg_shift_en), .cfg_data_in(cfg_data_in), .cfg_load(cfg_load),
    .cfg_data_out(a_dout)
  );

  e_term_loopback_cfg u_b (
    .UserCLK(clk), .rst(rst), .end_in(ch_end_in), .beg_out(b_beg),
    .cfg_shift_en(cfg_shift_en), .cfg_data_in(a_dout), .cfg_load(cfg_load),
    .cfg_data_out(b_dout)
  );

  // Model: history of reversed inputs indexed by clock-edge number.
  int             e      = 0;
  int             rst_e  = 0;
  logic           m_valid = 1'b0;
  logic [23:0]    m_shadow;
  logic [1:0]     m_mode [NG];
  logic [15:0]    m_lfsr;
  logic [W-1:0]   hist [256];

  function automatic logic [W-1:0] rev48(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic model_any_prbs();
    for (int g = 0; g < NG; g++) if (m_mode[g] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] model_beg(input logic [W-1:0] ein);
    logic [W-1:0] r;
    logic [W-1:0] rv;
    logic [W-1:0] piped;
    int idx;
    rv    = rev48(ein);
    idx   = e - DEPTH + 1;
    piped = (idx > rst_e) ? hist[idx % 256] : '0;
    for (int g = 0; g < NG; g++) begin
      for (int b = 0; b < GW; b++) begin
        int i;
        i = g * GW + b;
        case (m_mode[g])
          2'b00:   r[i] = rv[i];
          2'b01:   r[i] = piped[i];
          2'b10:   r[i] = 1'b0;
          default: r[i] = m_lfsr[i % 16];
        endcase
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    e <= e + 1;
    if (rst) begin
      rst_e    <= e + 1;
      m_shadow <= '0;
      for (int g = 0; g < NG; g++) m_mode[g] <= 2'b00;
      m_lfsr   <= SEED;
      m_valid  <= 1'b1;
    end else begin
      hist[(e + 1) % 256] <= rev48(end_in);
      if (model_any_prbs()) m_lfsr <= lfsr_next(m_lfsr);
      if (cfg_load) for (int g = 0; g < NG; g++) m_mode[g] <= m_shadow[2*g +: 2];
      if (cfg_shift_en) m_shadow <= {m_shadow[22:0], cfg_data_in};
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_beg_out", beg_out, model_beg(end_in));
      check("model_cfg_data_out", 48'(cfg_data_out), 48'(m_shadow[23]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_shift_en = 1'b1;
    cfg_data_in  = b;
    tick();
    cfg_shift_en = 1'b0;
    cfg_data_in  = 1'b0;
  endtask

  task automatic commit();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    logic [23:0] x;
    logic [47:0] wpat;
    logic [63:0] rnd;
    rst          = 1'b1;
    end_in       = 48'h0000_0000_0001;
    ch_end_in    = '1;
    cfg_shift_en = 1'b0;
    cfg_data_in  = 1'b0;
    cfg_load     = 1'b0;
    tick();
    @(negedge clk);
    check("reset_beg_out", beg_out, 48'h8000_0000_0000);
    check("reset_cfg_data_out", 48'(cfg_data_out), 48'h0);
    tick();
    rst    = 1'b0;
    end_in = '0;

    // Group 11 to PIPE.
    shift_bit(1'b0);
    shift_bit(1'b1);
    for (int i = 0; i < 22; i++) shift_bit(1'b0);
    commit();
    end_in = 48'h8000_0000_0001;
    @(negedge clk);
    check("pipe_cycle0", beg_out, 48'h0000_0000_0001);
    tick();
    end_in = '0;
    @(negedge clk);
    check("pipe_cycle1", beg_out, 48'h0);
    tick();
    @(negedge clk);
    check("pipe_cycle2", beg_out, 48'h8000_0000_0000);
    tick();
    @(negedge clk);
    check("pipe_cycle3", beg_out, 48'h0);

    // All PRBS, then back to BYPASS.
    for (int i = 0; i < 24; i++) shift_bit(1'b1);
    commit();
    @(negedge clk);
    check("prbs_first", 48'(beg_out[15:0]), 48'hACE1);
    tick();
    @(negedge clk);
    check("prbs_second", 48'(beg_out[15:0]), 48'h59C3);
    for (int i = 0; i < 24; i++) shift_bit(1'b0);
    commit();
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    check("bypass_after_prbs", beg_out, 48'h0);

    // Simultaneous load and shift: active takes old shadow.
    end_in = '1;
    x = 24'h400002;
    for (int i = 23; i >= 0; i--) shift_bit(x[i]);
    cfg_shift_en = 1'b1;
    cfg_data_in  = 1'b0;
    cfg_load     = 1'b1;
    tick();
    cfg_shift_en = 1'b0;
    cfg_load     = 1'b0;
    @(negedge clk);
    check("loadshift_dout", 48'(cfg_data_out), 48'h1);
    check("loadshift_beg", beg_out, 48'hFFFF_FFFF_FFF0);

    // Mid-stream reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midreset_beg", beg_out, 48'hFFFF_FFFF_FFFF);
    check("midreset_dout", 48'(cfg_data_out), 48'h0);

    // Daisy chain: first 24 bits reach tile B.
    wpat = {24'hAAAAAA, 24'h000002};
    for (int i = 47; i >= 0; i--) shift_bit(wpat[i]);
    @(negedge clk);
    check("chain_a_preload", a_beg, 48'hFFFF_FFFF_FFFF);
    check("chain_b_preload", b_beg, 48'hFFFF_FFFF_FFFF);
    commit();
    @(negedge clk);
    check("chain_a_commit", a_beg, 48'hFFFF_FFFF_FFF0);
    check("chain_b_commit", b_beg, 48'h0);
    check("chain_b_dout", 48'(b_dout), 48'h1);
    check("chain_a_dout", 48'(a_dout), 48'h0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rnd          = {$urandom(), $urandom()};
      end_in       = rnd[47:0];
      cfg_shift_en = ($urandom_range(0, 99) < 40);
      cfg_data_in  = $urandom_range(0, 1) == 1;
      cfg_load     = ($urandom_range(0, 99) < 6);
      rst          = ($urandom_range(0, 999) < 5);
      tick();
    end
    rst          = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_load     = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
